// File: rtl/rtc_mux_bus_ctrl_if.sv
// Signal bundle between the register-access sequencer, the RTC pins and the
// multiplexed-bus controller.
interface rtc_mux_bus_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic              wr_nrd;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ad_in;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic              a_d;
  logic              cs;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              busy;
  logic              done;

  // Sequencer and pad side
  modport master (
    output start, wr_nrd, addr, wdata, ad_in,
    input  ad_out, ad_oe, a_d, cs, wr, rd, rdata, rdata_valid, busy, done
  );

  // Controller side
  modport slave (
    input  start, wr_nrd, addr, wdata, ad_in,
    output ad_out, ad_oe, a_d, cs, wr, rd, rdata, rdata_valid, busy, done
  );
endinterface

// File: rtl/rtc_mux_bus_ctrl.sv
// Multiplexed address/data RTC bus controller: one address phase followed by a
// data write or read per start request, with fully registered pin outputs.
module rtc_mux_bus_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_ADDR  = 7,
  parameter int unsigned T_GAP   = 6,
  parameter int unsigned T_DATA  = 7,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  rtc_mux_bus_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(T_DATA - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ADDR, S_GAP, S_DATA, S_HOLD, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_nrd_q, wr_nrd_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DATA_W-1:0] ad_out_q, ad_out_d;
  logic              ad_oe_q, ad_oe_d;
  logic              a_d_q, a_d_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_c;

  // Next state, then pin values computed from the next state so they register
  // in step with it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    wr_nrd_d = wr_nrd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    last_c   = 1'b0;

    unique case (state_q)
      S_SETUP: last_c = (cnt_q == SETUP_LAST);
      S_ADDR:  last_c = (cnt_q == ADDR_LAST);
      S_GAP:   last_c = (cnt_q == GAP_LAST);
      S_DATA:  last_c = (cnt_q == DATA_LAST);
      S_HOLD:  last_c = (cnt_q == HOLD_LAST);
      default: last_c = 1'b0;
    endcase

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d  = S_SETUP;
          wr_nrd_d = bus.wr_nrd;
          addr_d   = bus.addr;
          wdata_d  = bus.wdata;
        end
      end
      S_SETUP: if (last_c) state_d = S_ADDR;
      S_ADDR:  if (last_c) state_d = S_GAP;
      S_GAP:   if (last_c) state_d = S_DATA;
      S_DATA: begin
        if (last_c) begin
          state_d = S_HOLD;
          // Read data is taken on the edge where rd rises
          if (!wr_nrd_q) rdata_d = bus.ad_in;
        end
      end
      S_HOLD:  if (last_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    a_d_d         = 1'b1;
    cs_d          = 1'b1;
    wr_d          = 1'b1;
    rd_d          = 1'b1;
    ad_oe_d       = 1'b0;
    ad_out_d      = '0;
    done_d        = 1'b0;
    rdata_valid_d = 1'b0;
    busy_d        = (state_d != S_IDLE);

    unique case (state_d)
      S_SETUP: begin
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      S_ADDR: begin
        a_d_d    = 1'b0;
        cs_d     = 1'b0;
        wr_d     = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      S_GAP: begin
        // First gap cycle keeps the address on the bus as hold time
        if (cnt_d == '0) begin
          a_d_d    = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = addr_d;
        end
      end
      S_DATA: begin
        cs_d = 1'b0;
        if (wr_nrd_d) begin
          wr_d     = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end else begin
          rd_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (wr_nrd_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      S_DONE: begin
        done_d        = 1'b1;
        rdata_valid_d = ~wr_nrd_d;
      end
      default: ;
    endcase
  end

  // State and registered pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_nrd_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      ad_out_q      <= '0;
      ad_oe_q       <= 1'b0;
      a_d_q         <= 1'b1;
      cs_q          <= 1'b1;
      wr_q          <= 1'b1;
      rd_q          <= 1'b1;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_nrd_q      <= wr_nrd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ad_out_q      <= ad_out_d;
      ad_oe_q       <= ad_oe_d;
      a_d_q         <= a_d_d;
      cs_q          <= cs_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.ad_out      = ad_out_q;
  assign bus.ad_oe       = ad_oe_q;
  assign bus.a_d         = a_d_q;
  assign bus.cs          = cs_q;
  assign bus.wr          = wr_q;
  assign bus.rd          = rd_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
